// File: rtl/fma_pkg.sv
// Shared constants and helpers for the FMA arbiter slice.
// Defaults match the reference configuration.
package fma_pkg;

  localparam int FP32_W    = 32;
  localparam int NREQ_DEF  = 4;
  localparam int LAT_DEF   = 4;
  localparam int DEPTH_DEF = 8;

  // ceil(log2(n)), never below 1 so ids always have a bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fma_result_fifo.sv
// Show-ahead result FIFO holding {id, data} pairs.
// Head entry is presented combinationally whenever count is non-zero.
module fma_result_fifo
  import fma_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = FP32_W + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [W-1:0]                wr_data,
  input  logic                        rd_en,
  output logic [W-1:0]                rd_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fma_arbiter.sv
// Round-robin share of one pipelined FP32 FMA among NREQ requesters.
// Credits bound in-flight ops to FIFO depth so the FMA never stalls.
module fma_arbiter
  import fma_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*FP32_W-1:0]    req_a,
  input  logic [NREQ*FP32_W-1:0]    req_b,
  input  logic [NREQ*FP32_W-1:0]    req_c,
  output logic                      fma_valid,
  output logic [FP32_W-1:0]         fma_a,
  output logic [FP32_W-1:0]         fma_b,
  output logic [FP32_W-1:0]         fma_c,
  input  logic [FP32_W-1:0]         fma_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [clog2(NREQ)-1:0]    rsp_id,
  output logic [FP32_W-1:0]         rsp_data
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(DEPTH + 1);
  localparam int FW  = IDW + FP32_W;

  logic [IDW-1:0]    rr_ptr;
  logic [CW-1:0]     outst;
  logic              can_issue;
  logic              found;
  logic              fire;
  logic              pop;
  logic [IDW-1:0]    gnt_id;
  logic [IDW:0]      idx;
  logic [IDW-1:0]    issue_id;

  logic [LAT-1:0]            tag_v;
  logic [LAT-1:0][IDW-1:0]   tag_id;

  logic [FW-1:0]     fdata;
  logic [CW-1:0]     fcount;

  logic [FP32_W-1:0] a_arr [NREQ];
  logic [FP32_W-1:0] b_arr [NREQ];
  logic [FP32_W-1:0] c_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[FP32_W*g +: FP32_W];
    assign b_arr[g] = req_b[FP32_W*g +: FP32_W];
    assign c_arr[g] = req_c[FP32_W*g +: FP32_W];
  end

  assign can_issue = !reset && (outst < CW'(DEPTH));
  assign fire      = found;
  assign req_ready = found ? (NREQ'(1) << gnt_id) : '0;

  // scan from rr_ptr upward with wrap; first valid requester wins
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && can_issue && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end

  // issue register: operands held when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      fma_valid <= 1'b0;
      fma_a     <= '0;
      fma_b     <= '0;
      fma_c     <= '0;
      issue_id  <= '0;
    end else begin
      fma_valid <= fire;
      if (fire) begin
        rr_ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0
                                               : gnt_id + IDW'(1);
        fma_a    <= a_arr[gnt_id];
        fma_b    <= b_arr[gnt_id];
        fma_c    <= c_arr[gnt_id];
        issue_id <= gnt_id;
      end
    end
  end

  // credits: ops issued but not yet consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // id shadow of the FMA pipeline, aligned with fma_result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= fma_valid;
      tag_id[0] <= issue_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid = (fcount != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = fdata[FP32_W +: IDW];
  assign rsp_data  = fdata[FP32_W-1:0];

  fma_result_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tag_v[LAT-1]),
    .wr_data ({tag_id[LAT-1], fma_result}),
    .rd_en   (pop),
    .rd_data (fdata),
    .count   (fcount)
  );

endmodule
